// File: rtl/mac_perf_counters.sv
// mac_perf_counters: performance/debug counter bank behind the MAC control unit.
// It counts busy cycles, completed jobs, engine stalls, the last job length and
// the longest job length. Results are read through a 1-cycle-latency debug window.
// Optional feature macro: MAC_PERF_STALL_CNT_EN adds the STALL counter at word 2.
// Without it, word 2 reads 0 and the engine valid/ready inputs are ignored.
//
// Debug window handshake: gnt_o is always 1, so a request is accepted in the
// cycle that req_i is high. r_valid_o rises exactly one cycle later. For a read
// (wen_i=1), r_data_o holds the register value as it was in the request cycle,
// before that cycle's updates. For a write (wen_i=0), r_data_o is 0. A new
// request may be issued in every cycle.
module mac_perf_counters #(
  parameter int N_CORES     = 2,
  parameter int N_EVT       = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int STATE_WIDTH = 4,
  parameter logic [STATE_WIDTH-1:0] IDLE_STATE = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [STATE_WIDTH-1:0]     fsm_state_i,
  input  logic [N_CORES*N_EVT-1:0]   evt_i,
  input  logic                       engine_valid_i,
  input  logic                       engine_ready_i,
  input  logic                       req_i,
  input  logic [31:0]                add_i,
  input  logic                       wen_i,
  input  logic [31:0]                data_i,
  output logic                       gnt_o,
  output logic [31:0]                r_data_o,
  output logic                       r_valid_o
);

  if (CNT_WIDTH < 8 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $fatal(1, "mac_perf_counters: CNT_WIDTH must be within 8..32");
  end

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_RUN  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Saturating increment shared by all counters and the job-length tracker.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [2:0]           word_idx;
  logic                 ctrl_wr;
  logic                 clr_all;
  logic                 not_idle;
  logic                 evt_q;
  logic                 evt_rise;
  logic                 freeze;
  logic [0:0]           t_state;
  logic [CNT_WIDTH-1:0] lat;
  logic                 job_done;
  logic [CNT_WIDTH-1:0] busy_cnt;
  logic [CNT_WIDTH-1:0] jobs_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic [CNT_WIDTH-1:0] max_cnt;
  logic [31:0]          rd_word;

  assign gnt_o    = 1'b1;
  assign word_idx = add_i[4:2];
  assign ctrl_wr  = req_i & ~wen_i & (word_idx == 3'd5);
  // clear_i and the CTRL clear-all bit act identically; neither touches freeze.
  assign clr_all  = clear_i | (ctrl_wr & data_i[1]);
  assign not_idle = (fsm_state_i != IDLE_STATE);
  assign evt_rise = evt_i[0] & ~evt_q;
  assign job_done = (t_state == T_RUN) & ~not_idle;

  // Freeze flag: only a CTRL write changes it; clears leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      freeze <= data_i[0];
    end
  end

  // End-of-job edge history. It also tracks the input during a clear.
  // That way an event held high across a clear does not count again.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_i[0];
    end
  end

  // Job-length tracker. It keeps running while frozen, so a job is never split.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_state <= T_IDLE;
      lat     <= '0;
    end else if (clr_all) begin
      t_state <= T_IDLE;
      lat     <= '0;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (not_idle) begin
            t_state <= T_RUN;
            lat     <= CNT_ONE;
          end
        end
        T_RUN: begin
          if (not_idle) begin
            lat <= sat_inc(lat);
          end else begin
            t_state <= T_IDLE;
          end
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  // BUSY/JOBS/LAST/MAX counters. They hold while frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cnt <= '0;
      jobs_cnt <= '0;
      last_cnt <= '0;
      max_cnt  <= '0;
    end else if (clr_all) begin
      busy_cnt <= '0;
      jobs_cnt <= '0;
      last_cnt <= '0;
      max_cnt  <= '0;
    end else if (!freeze) begin
      if (not_idle) busy_cnt <= sat_inc(busy_cnt);
      if (evt_rise) jobs_cnt <= sat_inc(jobs_cnt);
      if (job_done) begin
        last_cnt <= lat;
        if (lat > max_cnt) max_cnt <= lat;
      end
    end
  end

`ifdef MAC_PERF_STALL_CNT_EN
  // STALL counter: cycles where the engine offers data that is not taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (clr_all) begin
      stall_cnt <= '0;
    end else if (!freeze && engine_valid_i && !engine_ready_i) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`else
  logic unused_engine;
  assign unused_engine = engine_valid_i ^ engine_ready_i;
  assign stall_cnt     = '0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{evt_i, add_i[31:5], add_i[1:0], data_i[31:2]};

  // Read mux over the register map, using current (pre-update) values.
  always_comb begin
    rd_word = '0;
    case (word_idx)
      3'd0:    rd_word = 32'(busy_cnt);
      3'd1:    rd_word = 32'(jobs_cnt);
      3'd2:    rd_word = 32'(stall_cnt);
      3'd3:    rd_word = 32'(last_cnt);
      3'd4:    rd_word = 32'(max_cnt);
      3'd5:    rd_word = {30'd0, (t_state == T_RUN), freeze};
      default: rd_word = '0;
    endcase
  end

  // Response register: one-cycle latency. Writes return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_valid_o <= req_i;
      r_data_o  <= (req_i && wen_i) ? rd_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_mac_perf_counters.sv
// Bench for mac_perf_counters. It runs directed scenarios and then randomized
// traffic. Every debug-window response is compared against a behavioural model.
`timescale 1ns/1ps
module tb_mac_perf_counters;

  localparam int CW   = 8;
  localparam int NE   = 4;
  localparam int MAXV = (1 << CW) - 1;
`ifdef MAC_PERF_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic [3:0]    fsm_state_i = '0;
  logic [NE-1:0] evt_i = '0;
  logic          engine_valid_i = 1'b0;
  logic          engine_ready_i = 1'b0;
  logic          req_i = 1'b0;
  logic [31:0]   add_i = '0;
  logic          wen_i = 1'b1;
  logic [31:0]   data_i = '0;
  logic          gnt_o;
  logic [31:0]   r_data_o;
  logic          r_valid_o;

  int total = 0;
  int bad   = 0;

  mac_perf_counters #(
    .N_CORES(2), .N_EVT(2), .CNT_WIDTH(CW), .STATE_WIDTH(4), .IDLE_STATE(4'd0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .fsm_state_i(fsm_state_i),
    .evt_i(evt_i), .engine_valid_i(engine_valid_i), .engine_ready_i(engine_ready_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .data_i(data_i),
    .gnt_o(gnt_o), .r_data_o(r_data_o), .r_valid_o(r_valid_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks what each statistic means: cycle counts, a job in progress
  // with its running length, and min() for saturation.
  int m_busy, m_jobs, m_stall, m_last, m_max, m_len;
  bit m_freeze, m_run, m_prev;
  logic [31:0] exp_q[$];
  bit exp_v;

  function automatic int inc_sat(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return 32'(m_busy);
      1: return 32'(m_jobs);
      2: return STALL_EN ? 32'(m_stall) : 32'd0;
      3: return 32'(m_last);
      4: return 32'(m_max);
      5: return {30'd0, m_run, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    int idx;
    bit ctrl_wr, clr, active, nxt_freeze;
    if (!rst_ni) begin
      m_busy = 0; m_jobs = 0; m_stall = 0; m_last = 0; m_max = 0; m_len = 0;
      m_freeze = 0; m_run = 0; m_prev = 0;
      exp_q.delete();
      exp_v = 0;
    end else begin
      idx = int'(add_i[4:2]);
      exp_v = req_i;
      if (req_i) exp_q.push_back(wen_i ? model_read(idx) : 32'd0);
      ctrl_wr = req_i && !wen_i && (idx == 5);
      clr = clear_i || (ctrl_wr && data_i[1]);
      nxt_freeze = ctrl_wr ? data_i[0] : m_freeze;
      active = (fsm_state_i != 4'd0);
      if (clr) begin
        m_busy = 0; m_jobs = 0; m_stall = 0; m_last = 0; m_max = 0;
        m_run = 0; m_len = 0;
      end else begin
        if (!m_freeze) begin
          if (active) m_busy = inc_sat(m_busy);
          if (evt_i[0] && !m_prev) m_jobs = inc_sat(m_jobs);
          if (engine_valid_i && !engine_ready_i) m_stall = inc_sat(m_stall);
        end
        if (m_run && !active) begin
          if (!m_freeze) begin
            m_last = m_len;
            m_max  = (m_len > m_max) ? m_len : m_max;
          end
          m_run = 0;
        end else if (m_run) begin
          m_len = inc_sat(m_len);
        end else if (active) begin
          m_run = 1;
          m_len = 1;
        end
      end
      m_prev = evt_i[0];
      m_freeze = nxt_freeze;
    end
  end

  // Scoreboard: check every response against the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("r_valid", {31'd0, r_valid_o}, {31'd0, exp_v});
      if (exp_v && exp_q.size() > 0) chk("r_data", r_data_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'(idx) << 2;
    tick();
    req_i = 1'b0;
    d = r_data_o;
    chk("r_valid_lat", {31'd0, r_valid_o}, 32'd1);
    chk("gnt", {31'd0, gnt_o}, 32'd1);
  endtask

  task automatic check_reg(input string tag, input int idx, input int exp);
    logic [31:0] d;
    rd(idx, d);
    chk(tag, d, 32'(exp));
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'(idx) << 2; data_i = d;
    tick();
    req_i = 1'b0; wen_i = 1'b1; data_i = '0;
  endtask

  task automatic job(input int len);
    fsm_state_i = 4'($urandom_range(1, 15));
    repeat (len) tick();
    fsm_state_i = 4'd0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    rst_ni = 1'b0;
    repeat (3) tick();
    chk("rst_r_valid", {31'd0, r_valid_o}, 32'd0);
    chk("rst_r_data", r_data_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // reset values of all words
    for (int i = 0; i < 8; i++) check_reg("rst_word", i, 0);

    // single 10-cycle job
    job(10);
    check_reg("busy10", 0, 10);
    check_reg("last10", 3, 10);
    check_reg("max10", 4, 10);
    check_reg("ctrl_idle", 5, 0);

    // jobs of 5 then 3, two end-of-job pulses
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    job(5); tick();
    job(3);
    repeat (2) begin evt_i = 4'b0001; tick(); evt_i = '0; tick(); end
    check_reg("last3", 3, 3);
    check_reg("max5", 4, 5);
    check_reg("jobs2", 1, 2);
    check_reg("busy8", 0, 8);

    // event held high across a clear is not recounted
    evt_i = 4'b0001; clear_i = 1'b1; tick(); clear_i = 1'b0;
    repeat (3) tick();
    evt_i = '0;
    check_reg("jobs_held", 1, 0);

    // stalls: accepted beats do not count, refused beats do
    engine_valid_i = 1'b1; engine_ready_i = 1'b1; repeat (3) tick();
    engine_ready_i = 1'b0; repeat (7) tick();
    engine_valid_i = 1'b0;
    check_reg("stall7", 2, STALL_EN ? 7 : 0);

    // saturation at CNT_WIDTH=8, then clear-all through CTRL
    job(300);
    check_reg("busy_sat", 0, MAXV);
    check_reg("last_sat", 3, MAXV);
    check_reg("max_sat", 4, MAXV);
    wr(5, 32'd2);
    for (int i = 0; i < 5; i++) check_reg("clr_all", i, 0);

    // freeze holds counters while the tracker keeps running
    job(2);
    check_reg("busy2", 0, 2);
    wr(5, 32'd1);
    fsm_state_i = 4'd7; repeat (2) tick();
    check_reg("ctrl_run_frz", 5, 3);
    repeat (2) tick();
    fsm_state_i = 4'd0; tick();
    check_reg("busy_frz", 0, 2);
    check_reg("last_frz", 3, 2);
    clear_i = 1'b1; wr(5, 32'd1); clear_i = 1'b0;
    check_reg("busy_clr", 0, 0);
    check_reg("max_clr", 4, 0);
    check_reg("ctrl_frz_kept", 5, 1);
    wr(5, 32'd0);

    // job end in the same cycle as a LAST read returns the old value
    job(2);
    fsm_state_i = 4'd3; repeat (6) tick();
    fsm_state_i = 4'd0;
    rd(3, d);
    chk("last_old", d, 32'd2);
    check_reg("last_new", 3, 6);

    // randomized traffic, checked by the scoreboard
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)
        fsm_state_i = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) evt_i = 4'($urandom);
      engine_valid_i = 1'($urandom_range(0, 1));
      engine_ready_i = 1'($urandom_range(0, 1));
      clear_i = ($urandom_range(0, 199) == 0);
      req_i = 1'($urandom_range(0, 1));
      wen_i = ($urandom_range(0, 11) != 0);
      add_i = $urandom;
      data_i = $urandom;
      if ($urandom_range(0, 3) != 0) data_i[1] = 1'b0;
      tick();
    end
    req_i = 1'b0; wen_i = 1'b1; clear_i = 1'b0;
    fsm_state_i = '0; evt_i = '0; engine_valid_i = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
